// File: rtl/mult_job_sequencer_if.sv
// Job/result handshake bundle between an upstream controller and the
// multiplier job sequencer. The sequencer is the slave on both channels:
// it consumes operand pairs and produces results.
interface mult_job_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_multiplier;
    logic [7:0]  in_multiplicand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_timeout;

    modport slave (
        input  in_valid, in_multiplier, in_multiplicand, out_ready,
        output in_ready, out_valid, out_product, out_timeout
    );

    modport master (
        output in_valid, in_multiplier, in_multiplicand, out_ready,
        input  in_ready, out_valid, out_product, out_timeout
    );
endinterface

// File: rtl/mult_job_sequencer.sv
// Upstream job controller for the Robertson 8x8 signed multiplier.
// Accepts an operand pair, holds the multiplier in reset for RST_CYCLES,
// releases it, waits for a fresh rising edge of its done level (or a
// watchdog timeout) and presents the captured product on a result port.
// Every output comes straight from a flop; no input reaches an output
// combinationally.
module mult_job_sequencer #(
    parameter int unsigned RST_CYCLES = 2,    // 1..15
    parameter int unsigned TIMEOUT    = 127   // 1..255
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_job_sequencer_if.slave  job_if,
    output logic                 mul_reset_o,
    output logic [7:0]           mul_multiplier_o,
    output logic [7:0]           mul_multiplicand_o,
    input  logic [15:0]          mul_product_i,
    input  logic                 mul_done_i,
    output logic                 busy_o,
    output logic [7:0]           job_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] LOAD_LAST = 4'(RST_CYCLES - 1);
    localparam logic [7:0] RUN_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  load_cnt_q;
    logic [7:0]  run_cnt_q;
    logic        done_q;
    logic        in_ready_q;
    logic        mul_reset_q;
    logic        busy_q;
    logic        out_valid_q;
    logic        out_timeout_q;
    logic [15:0] out_product_q;
    logic [7:0]  mul_multiplier_q;
    logic [7:0]  mul_multiplicand_q;
    logic [7:0]  job_count_q;
    logic        done_edge_s;

    // Qualify done: only a low-to-high transition seen while running counts,
    // so a level left high from before the restart can never complete a job.
    always_comb begin
        done_edge_s = 1'b0;
        if (state_q == RUN) begin
            done_edge_s = mul_done_i & ~done_q;
        end else begin
            done_edge_s = 1'b0;
        end
    end

    // Delayed copy of the multiplier done level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= mul_done_i;
        end
    end

    // Job sequencing FSM with all handshake and multiplier controls registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            load_cnt_q         <= 4'd0;
            run_cnt_q          <= 8'd0;
            in_ready_q         <= 1'b1;
            mul_reset_q        <= 1'b1;
            busy_q             <= 1'b0;
            out_valid_q        <= 1'b0;
            out_timeout_q      <= 1'b0;
            out_product_q      <= 16'h0000;
            mul_multiplier_q   <= 8'h00;
            mul_multiplicand_q <= 8'h00;
            job_count_q        <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_if.in_valid && in_ready_q) begin
                        mul_multiplier_q   <= job_if.in_multiplier;
                        mul_multiplicand_q <= job_if.in_multiplicand;
                        load_cnt_q         <= 4'd0;
                        in_ready_q         <= 1'b0;
                        busy_q             <= 1'b1;
                        state_q            <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        mul_reset_q <= 1'b0;
                        run_cnt_q   <= 8'd0;
                        state_q     <= RUN;
                    end else begin
                        load_cnt_q <= load_cnt_q + 4'd1;
                    end
                end
                RUN: begin
                    if (done_edge_s) begin
                        // A real completion beats a coincident watchdog expiry.
                        out_product_q <= mul_product_i;
                        out_timeout_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        mul_reset_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else if (run_cnt_q == RUN_LAST) begin
                        out_product_q <= 16'h0000;
                        out_timeout_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        mul_reset_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        run_cnt_q <= run_cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    // No operand accept here; in_ready only rises once back in IDLE.
                    if (job_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        job_count_q <= job_count_q + 8'd1;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    mul_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign job_if.in_ready     = in_ready_q;
    assign job_if.out_valid    = out_valid_q;
    assign job_if.out_product  = out_product_q;
    assign job_if.out_timeout  = out_timeout_q;
    assign mul_reset_o         = mul_reset_q;
    assign mul_multiplier_o    = mul_multiplier_q;
    assign mul_multiplicand_o  = mul_multiplicand_q;
    assign busy_o              = busy_q;
    assign job_count_o         = job_count_q;

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Upstream job controller for the Robertson's 8x8 signed multiplier datapath/FSM.
- Accepts operand pairs over a valid/ready interface and registers them.
- Holds the multiplier in reset long enough to restart it, then releases it and waits for a qualified done edge.
- Captures the 16-bit product and presents it on a valid/ready result port.
- A watchdog converts a missing done into a flagged timeout result.

Parameters:
RST_CYCLES, 2, cycles mul_reset is held after operand accept (legal range 1..15)
TIMEOUT, 127, maximum cycles spent in RUN waiting for done (legal range 1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept operands
in_multiplier  in  8  signed multiplier operand
in_multiplicand  in  8  signed multiplicand operand
mul_reset  out  1  reset to the multiplier; high restarts it
mul_multiplier  out  8  registered operand to multiplier
mul_multiplicand  out  8  registered operand to multiplier
mul_product  in  16  multiplier product
mul_done  in  1  multiplier done level
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  16  captured signed product
out_timeout  out  1  result produced by watchdog, not by done
busy  out  1  high in LOAD or RUN
job_count  out  8  completed result handshakes, wraps 255->0

Behaviour:
- Reset values:
  - state IDLE; in_ready 1; mul_reset 1.
  - mul_multiplier, mul_multiplicand, out_product, job_count = 0.
  - out_valid, out_timeout, busy = 0.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- States:
  - IDLE: mul_reset=1, in_ready=1. When in_valid&in_ready at edge E0: latch operands into mul_*, clear the load counter, go LOAD.
  - LOAD: mul_reset=1, busy=1. Stay RST_CYCLES cycles. At edge E0+RST_CYCLES go RUN; mul_reset low from that edge.
  - RUN: mul_reset=0, busy=1. run_cnt clears on entry and increments each RUN cycle.
  - HOLD: out_valid=1; out_product and out_timeout are stable. When out_ready is high at an edge, go IDLE, clear out_valid, and increment job_count (mod 256).
- Done qualification:
  - done_q = mul_done registered every cycle.
  - done_edge = mul_done & ~done_q, evaluated only in RUN.
  - A done level that stays high across mul_reset never qualifies. That case times out, by design.
- RUN exit on done_edge: out_product<=mul_product, out_timeout<=0, go HOLD. out_valid rises on the same edge.
- RUN exit on timeout: when run_cnt==TIMEOUT-1 and no done_edge, set out_product<=16'h0000, out_timeout<=1, go HOLD. RUN lasts at most TIMEOUT cycles.
- Simultaneous done_edge and timeout terminal count: done_edge wins, out_timeout=0.
- Operand registers:
  - Change only on input accept.
  - Stay stable through LOAD, RUN, HOLD and the following IDLE.
- in_valid outside IDLE is ignored. No accept occurs in HOLD, even in the same cycle as out_ready.
- in_ready rises the cycle after the out handshake edge. Minimum job-to-job spacing is therefore 1 + RST_CYCLES + run + 1 cycles.
- Asynchronous reset in any state:
  - Immediately returns all registers to their reset values, including job_count=0.
  - mul_reset asserts, so the multiplier is also restarted.
  - Any in-flight or unconsumed result is discarded.
- Width rules:
  - Product is passed through unmodified as 16-bit two's complement.
  - run_cnt is 8 bits.
  - Load counter is 4 bits.

Test Plan:
- Basic: accept 0x03*0x05. Model asserts done rising edge after 40 RUN cycles -> out_valid with out_product=0x000F, out_timeout=0. mul_reset high exactly 2 cycles after accept. job_count 0->1 on out handshake.
- Signed: 0xFD*0x05 -> out_product=0xFFF1. 0x80*0x80 -> 0x4000. 0x7F*0x80 -> 0xC080. Operands stable on mul_* throughout RUN.
- Timeout/stale done: model holds mul_done=1 continuously -> exactly 127 RUN cycles, then out_valid=1, out_timeout=1, out_product=0x0000. Repeat with mul_done stuck at 0 -> same result.
- Race: done rising edge in RUN cycle 127 (terminal count) -> out_timeout=0, product captured.
- Backpressure: out_ready low for 10 cycles -> out_valid and out_product stable, in_ready=0, pulsed in_valid not accepted. Then out_ready=1 -> IDLE next cycle. 256 completed jobs -> job_count wraps to 0.
- Reset mid-RUN (cycle 20) -> IDLE immediately, mul_reset=1, out_valid=0, job_count=0. The next job completes normally with the correct product.
